// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM-pipeline data memory path.
// Holds the SRAM controller FSM state type, SRAM bus widths, the default
// base address of data memory and the latched request record.
package arm_mem_pkg;

  localparam int SRAM_AW = 18;   // half-word address width
  localparam int SRAM_DW = 16;   // SRAM data bus width
  localparam int WIDX_W  = SRAM_AW - 1;  // 32-bit word index width

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } mem_state_t;

  // Request captured in IDLE and held for the whole access.
  typedef struct packed {
    logic        is_wr;   // 1 = write; rd_en wins when both are high
    logic        err;     // address failed the range check
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_wait_cnt.sv
// 3-bit wait-state down-counter for the SRAM controller.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - load load_val (has priority over dec)
//   load_val  - phase length in cycles (1..7)
//   dec       - decrement by one (saturates at 0)
//   cnt       - current count
//   tc        - terminal count: this is the last cycle of the phase
module sram_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= 3'd0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != 3'd0)  cnt <= cnt - 3'd1;
  end

  // Count is loaded with the phase length, so value 1 marks its last cycle.
  assign tc = (cnt == 3'd1);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit data memory controller in front of a 16-bit asynchronous SRAM.
// Each access is split into a LOW half-word phase and a HIGH half-word
// phase of WAIT_CYCLES cycles each, followed by a one-cycle DONE.
// The pipeline is frozen while ready is 0.
//
// Parameters:
//   WAIT_CYCLES - cycles per half-word phase, 1..7
//   BASE_ADDR   - first byte address of data memory
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   rd_en/wr_en  - MEM-stage request (both high = read)
//   address      - byte address, write_data - store data
//   read_data    - load data, held until the next read completes
//   ready        - access complete / idle
//   sram_addr    - half-word address, sram_dq_out/sram_dq_in - data bus
//   sram_dq_oe   - data bus drive enable, sram_we_n - write strobe
//   addr_err     - sticky address error flag
// Build option:
//   SRAM_CTRL_RANGE_CHK_EN - flag accesses below BASE_ADDR or misaligned;
//                            such accesses never strobe the SRAM and read 0.
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_dq_oe,
  output logic                sram_we_n,
  output logic                addr_err
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  mem_state_t         state, state_nxt;
  mem_req_t           req_q;
  logic               req_hit;
  logic               latch;
  logic               cnt_load, cnt_dec, cnt_tc;
  logic [2:0]         cnt;
  logic               new_err;
  logic [WIDX_W-1:0]  widx;
  logic               do_wr;

  assign req_hit = rd_en | wr_en;

`ifdef SRAM_CTRL_RANGE_CHK_EN
  assign new_err = (address < BASE_ADDR) || (address[1:0] != 2'b00);
`else
  assign new_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Wait-state counter
  // ---------------------------------------------------------------------
  sram_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_hit) begin
          latch     = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_LOW;
        end else begin
          ready = 1'b1;
        end
      end
      ST_LOW: begin
        // Reload on the last LOW cycle so HIGH gets a full phase.
        if (cnt_tc) begin
          cnt_load  = 1'b1;
          state_nxt = ST_HIGH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HIGH: begin
        cnt_dec = 1'b1;
        if (cnt_tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ready     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if (latch) begin
      req_q.is_wr <= wr_en & ~rd_en;
      req_q.err   <= new_err;
      req_q.addr  <= address;
      req_q.wdata <= write_data;
    end
  end

`ifdef SRAM_CTRL_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 addr_err <= 1'b0;
    else if (latch && new_err) addr_err <= 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read data capture: sample the bus on the last cycle of each phase,
  // when the SRAM has had the full wait time to settle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!req_q.is_wr && cnt_tc) begin
      if (state == ST_LOW)
        read_data[15:0]  <= req_q.err ? 16'h0000 : sram_dq_in;
      else if (state == ST_HIGH)
        read_data[31:16] <= req_q.err ? 16'h0000 : sram_dq_in;
    end
  end

  // ---------------------------------------------------------------------
  // SRAM bus. Decoded only from registered state, so a reset drops the
  // strobe immediately and nothing restarts until a fresh request.
  // ---------------------------------------------------------------------
  assign widx  = WIDX_W'((req_q.addr - BASE_ADDR) >> 2);
  assign do_wr = req_q.is_wr && !req_q.err &&
                 (state == ST_LOW || state == ST_HIGH);

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    case (state)
      ST_LOW:  sram_addr = {widx, 1'b0};
      ST_HIGH: sram_addr = {widx, 1'b1};
      default: sram_addr = '0;
    endcase
    if (do_wr)
      sram_dq_out = (state == ST_HIGH) ? req_q.wdata[31:16] : req_q.wdata[15:0];
  end

  assign sram_we_n  = ~do_wr;
  assign sram_dq_oe = do_wr;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed testbench for sram_ctrl: write, read, back-to-back, dual request,
// mid-access reset, WAIT_CYCLES=1 timing and (when SRAM_CTRL_RANGE_CHK_EN is
// defined) the address range check.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en, wr_en, rd_en1, wr_en1;
  logic [31:0] address, write_data;

  logic [31:0] read_data, read_data1;
  logic        ready, ready1;
  logic [17:0] sram_addr, sram_addr1;
  logic [15:0] sram_dq_out, sram_dq_out1, sram_dq_in, sram_dq_in1;
  logic        sram_dq_oe, sram_dq_oe1, sram_we_n, sram_we_n1;
  logic        addr_err, addr_err1;

  int checks = 0;
  int failures = 0;

  // SRAM model with a backdoor preload port
  logic [15:0] mem [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = '0;
  logic [15:0] bd_val = '0;

  assign sram_dq_in  = mem[sram_addr[3:0]];
  assign sram_dq_in1 = 16'h5A5A;

  always @(posedge clk) begin
    if (bd_we)           mem[bd_idx] <= bd_val;
    else if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
  end

  sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n),
    .addr_err(addr_err)
  );

  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1),
    .address(address), .write_data(write_data), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1),
    .addr_err(addr_err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bd(input logic [3:0] idx, input logic [15:0] val);
    tick(); bd_we = 1'b1; bd_idx = idx; bd_val = val;
    tick(); bd_we = 1'b0;
  endtask

  // Issue a one-cycle request and count cycles with ready low, from the
  // request cycle on. Returns sitting at the negedge of the ready cycle.
  task automatic req_count(input bit on1, input bit wr, input bit rd,
                           input logic [31:0] a, input logic [31:0] d,
                           output int n);
    tick();
    address = a; write_data = d;
    if (on1) begin wr_en1 = wr; rd_en1 = rd; end
    else     begin wr_en  = wr; rd_en  = rd; end
    n = 0;
    @(negedge clk);
    while (((on1 ? ready1 : ready) == 1'b0) && n < 40) begin
      n++;
      tick();
      wr_en = 0; rd_en = 0; wr_en1 = 0; rd_en1 = 0;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst = 1'b0; rd_en = 0; wr_en = 0; rd_en1 = 0; wr_en1 = 0;
    address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_ready", ready, 1);
    chk("rst_read_data", read_data, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_addr_err", addr_err, 0);
    rst = 1'b1;

    // write 0xDEADBEEF to 1028
    tick(); wr_en = 1; address = 32'd1028; write_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_c0_ready", ready, 0);
    for (int c = 1; c <= 4; c++) begin
      tick(); wr_en = 0;
      @(negedge clk);
      chk($sformatf("wr_c%0d_ready", c), ready, 0);
      chk($sformatf("wr_c%0d_addr", c), sram_addr, (c <= 2) ? 32'd2 : 32'd3);
      chk($sformatf("wr_c%0d_dq", c), sram_dq_out, (c <= 2) ? 32'hBEEF : 32'hDEAD);
      chk($sformatf("wr_c%0d_we_n", c), sram_we_n, 0);
      chk($sformatf("wr_c%0d_oe", c), sram_dq_oe, 1);
    end
    tick(); @(negedge clk);
    chk("wr_c5_ready", ready, 1);
    chk("wr_c5_we_n", sram_we_n, 1);
    chk("wr_c5_dq_out", sram_dq_out, 0);
    chk("wr_mem2", mem[2], 32'hBEEF);
    chk("wr_mem3", mem[3], 32'hDEAD);

    // read 0xABCD1234 from 1028
    bd(4'd2, 16'h1234);
    bd(4'd3, 16'hABCD);
    tick(); rd_en = 1; address = 32'd1028;
    @(negedge clk);
    chk("rd_c0_ready", ready, 0);
    for (int c = 1; c <= 4; c++) begin
      tick(); rd_en = 0;
      @(negedge clk);
      chk($sformatf("rd_c%0d_we_n", c), sram_we_n, 1);
      chk($sformatf("rd_c%0d_oe", c), sram_dq_oe, 0);
      chk($sformatf("rd_c%0d_ready", c), ready, 0);
    end
    tick(); @(negedge clk);
    chk("rd_ready", ready, 1);
    chk("rd_data", read_data, 32'hABCD1234);

    // back-to-back writes, wr_en held through DONE
    tick(); wr_en = 1; address = 32'd1028; write_data = 32'h11112222;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin n++; tick(); @(negedge clk); end
    chk("b2b_first_low", n, 5);
    tick(); address = 32'd1032; write_data = 32'h33334444;
    @(negedge clk);
    chk("b2b_idle_ready", ready, 0);
    tick(); @(negedge clk);
    chk("b2b_addr", sram_addr, 4);
    chk("b2b_dq", sram_dq_out, 32'h4444);
    n = 1;
    while (!ready && n < 40) begin n++; tick(); wr_en = 0; @(negedge clk); end
    chk("b2b_second_low", n, 5);
    chk("rd_hold", read_data, 32'hABCD1234);
    chk("b2b_mem2", mem[2], 32'h2222);

    // rd_en and wr_en together: a read of 1032
    req_count(1'b0, 1'b1, 1'b1, 32'd1032, 32'hFFFFFFFF, n);
    chk("dual_low", n, 5);
    chk("dual_data", read_data, 32'h33334444);
    chk("dual_mem4", mem[4], 32'h4444);

    // reset in second LOW cycle of a write
    tick(); wr_en = 1; address = 32'd1028; write_data = 32'h55556666;
    tick(); wr_en = 0;
    tick();
    chk("rstmid_pre_we_n", sram_we_n, 0);
    rst = 1'b0;
    #1;
    chk("rstmid_we_n", sram_we_n, 1);
    chk("rstmid_ready", ready, 1);
    chk("rstmid_addr", sram_addr, 0);
    chk("rstmid_rdata", read_data, 0);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstpost%0d_we_n", c), sram_we_n, 1);
      chk($sformatf("rstpost%0d_ready", c), ready, 1);
    end

    // WAIT_CYCLES = 1
    req_count(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0BADF00D, n);
    chk("w1_wr_low", n, 3);
    req_count(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, n);
    chk("w1_rd_low", n, 3);
    chk("w1_rd_data", read_data1, 32'h5A5A5A5A);

`ifdef SRAM_CTRL_RANGE_CHK_EN
    req_count(1'b0, 1'b0, 1'b1, 32'd1000, 32'h0, n);
    chk("rng_low", n, 5);
    chk("rng_err", addr_err, 1);
    chk("rng_data", read_data, 0);
    req_count(1'b0, 1'b1, 1'b0, 32'd1030, 32'hCAFECAFE, n);
    chk("rng_mis_low", n, 5);
    chk("rng_mis_mem2", mem[2], 32'h6666);
    req_count(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, n);
    chk("rng_sticky", addr_err, 1);
`else
    // no range check: 1000 maps to word index 0x1FFFA
    tick(); rd_en = 1; address = 32'd1000;
    tick(); rd_en = 0;
    @(negedge clk);
    chk("norng_addr", sram_addr, 32'h3FFF4);
    chk("norng_err", addr_err, 0);
    repeat (5) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
- REQ-001 SHALL have parameter WAIT_CYCLES, default 2: cycles per half-word SRAM phase, legal range 1..7.
- REQ-002 SHALL have parameter BASE_ADDR, default 1024: first byte address of data memory.
- REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
- REQ-005 SHALL have port rd_en, input, 1 bit: read request from the MEM stage.
- REQ-006 SHALL have port wr_en, input, 1 bit: write request from the MEM stage.
- REQ-007 SHALL have port address, input, 32 bits: byte address (ALU result).
- REQ-008 SHALL have port write_data, input, 32 bits: store data (Rm value).
- REQ-009 SHALL have port read_data, output, 32 bits: load data.
- REQ-010 SHALL have port ready, output, 1 bit: access complete; the pipeline freezes while it is 0.
- REQ-011 SHALL have port sram_addr, output, 18 bits: half-word address.
- REQ-012 SHALL have port sram_dq_out, output, 16 bits: write data to SRAM.
- REQ-013 SHALL have port sram_dq_in, input, 16 bits: read data from SRAM.
- REQ-014 SHALL have port sram_dq_oe, output, 1 bit: drive enable for the data bus.
- REQ-015 SHALL have port sram_we_n, output, 1 bit: SRAM write strobe, active-low.
- REQ-016 SHALL have port addr_err, output, 1 bit: sticky address error flag.

Function
- REQ-017 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
- REQ-018 IDLE with rd_en or wr_en SHALL latch address, write_data and the request type, then go to LOW; rd_en and wr_en both high SHALL be treated as a read.
- REQ-019 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, counted by a 3-bit down-counter; LOW then HIGH, then DONE.
- REQ-020 DONE SHALL last one cycle, then return to IDLE unconditionally; a request held high in that IDLE cycle SHALL start a new access.
- REQ-021 ready SHALL be combinational:
  - 1 in DONE;
  - 1 in IDLE with no request;
  - 0 otherwise.
  With W=WAIT_CYCLES, ready SHALL be 0 for exactly 2W+1 cycles from the first request cycle.
- REQ-022 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to 17 bits; sram_addr SHALL be {index, 0} in LOW and {index, 1} in HIGH.
- REQ-023 Write:
  - sram_dq_oe=1 and sram_we_n=0 for all cycles of LOW and HIGH;
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
- REQ-024 Read:
  - sram_we_n=1 and sram_dq_oe=0;
  - sram_dq_in SHALL be registered into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle;
  - read_data SHALL hold its value until the next read completes.
- REQ-025 Outside a write, sram_we_n SHALL be 1, sram_dq_oe 0 and sram_dq_out 0.

Reset
- REQ-026 rst=0 SHALL asynchronously force:
  - state IDLE and counter 0;
  - read_data 0;
  - sram_addr 0, sram_we_n 1, sram_dq_oe 0, sram_dq_out 0;
  - addr_err 0.
- REQ-027 Reset asserted mid-access SHALL abort the access; no partial write strobe SHALL follow the release of reset.

Configuration
- REQ-028 With SRAM_CTRL_RANGE_CHK_EN defined, an access with address < BASE_ADDR or address[1:0] != 0 SHALL set addr_err, keep sram_we_n=1, still complete the full handshake timing, and return read_data=0.
- REQ-029 Without SRAM_CTRL_RANGE_CHK_EN, addr_err SHALL be tied 0 and no range check SHALL be performed.

Structure
- REQ-030 Shared package arm_mem_pkg SHALL hold the FSM state type, the SRAM address and data widths, and the BASE_ADDR default.
- REQ-031 The wait counter SHALL be a sub-module sram_wait_cnt (load, decrement, terminal-count output); everything else SHALL stay in sram_ctrl.

Verification
- REQ-032 Write test: W=2, wr_en, address=1028, write_data=0xDEADBEEF ->
  - cycles 1-2: sram_addr=2, dq_out=0xBEEF, we_n=0;
  - cycles 3-4: sram_addr=3, dq_out=0xDEAD, we_n=0;
  - ready low for cycles 0-4, high on cycle 5.
- REQ-033 Read test: SRAM model holds 0x1234 at half-word 2 and 0xABCD at half-word 3; rd_en, address=1028 -> read_data=0xABCD1234 on the ready cycle, and we_n stays 1 throughout.
- REQ-034 Back-to-back test: wr_en held through DONE with address changed to 1032 in the following IDLE cycle -> second access begins immediately with sram_addr=4, and there is no ready glitch between the accesses.
- REQ-035 Reset test: rst=0 in the second LOW cycle of a write -> we_n=1 and state IDLE at once; after release with no request, ready=1 and no SRAM activity.
- REQ-036 Range-check test (macro defined): rd_en, address=1000 -> addr_err=1 (sticky), read_data=0, ready after 2W+1 cycles.
- REQ-037 W=1 test: ready low for exactly 3 cycles per access.
